// File: rtl/comparator_4bit_eq.sv
// 4-bit equality comparator: combinational equal/diff plus sampled result and sticky-mismatch status.
// Optional match/mismatch counters are enabled by defining COMP_EQ_STATS_EN.
module comparator_4bit_eq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic             sample,
  input  logic             clr,
  output logic             equal,
  output logic [3:0]       diff,
  output logic             equal_q,
  output logic             valid_q,
`ifdef COMP_EQ_STATS_EN
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
`endif
  output logic             mismatch_seen
);

  // Datapath decode path: independent of clock, reset and control.
  assign equal = (A == B);
  assign diff  = A ^ B;

  // Last sampled result and its one-cycle valid strobe; clr does not affect these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      equal_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= sample;
      if (sample) begin
        equal_q <= equal;
      end
    end
  end

  // Sticky mismatch flag; clear wins over a simultaneous sampled mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_seen <= 1'b0;
    end else if (clr) begin
      mismatch_seen <= 1'b0;
    end else if (sample && !equal) begin
      mismatch_seen <= 1'b1;
    end
  end

`ifdef COMP_EQ_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else if (clr) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else if (sample) begin
      if (equal) begin
        if (match_cnt != CNT_MAX) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end else begin
        if (mismatch_cnt != CNT_MAX) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_comparator_4bit_eq.sv
// Directed self-checking bench for comparator_4bit_eq (counter checks only when COMP_EQ_STATS_EN is defined).
module tb_comparator_4bit_eq;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             clk_en = 1'b0;
  logic             rst_n;
  logic [3:0]       A;
  logic [3:0]       B;
  logic             sample;
  logic             clr;
  logic             equal;
  logic [3:0]       diff;
  logic             equal_q;
  logic             valid_q;
  logic             mismatch_seen;
`ifdef COMP_EQ_STATS_EN
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  comparator_4bit_eq #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (A),
    .B             (B),
    .sample        (sample),
    .clr           (clr),
    .equal         (equal),
    .diff          (diff),
    .equal_q       (equal_q),
    .valid_q       (valid_q),
`ifdef COMP_EQ_STATS_EN
    .match_cnt     (match_cnt),
    .mismatch_cnt  (mismatch_cnt),
`endif
    .mismatch_seen (mismatch_seen)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nvec++;
    if ({equal_q, valid_q, mismatch_seen} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_regs: got eq_q/vld_q/seen=%b%b%b want 000", equal_q, valid_q, mismatch_seen);
    end
`ifdef COMP_EQ_STATS_EN
    nvec++;
    if (match_cnt !== 2'd0 || mismatch_cnt !== 2'd0) begin
      nerr++;
      $display("FAIL reset_cnt: got match=%0d mismatch=%0d want 0 0", match_cnt, mismatch_cnt);
    end
`endif
  endtask

  task automatic test_comb_sweep();
    logic [3:0] va [4] = '{4'b0000, 4'b1010, 4'b1100, 4'b1111};
    logic [3:0] vb [4] = '{4'b0000, 4'b1010, 4'b0011, 4'b1110};
    logic       xe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] xd [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      A = va[i];
      B = vb[i];
      #10;
      nvec++;
      if (equal !== xe[i] || diff !== xd[i]) begin
        nerr++;
        $display("FAIL comb_vec%0d: got equal=%b diff=%b want equal=%b diff=%b", i, equal, diff, xe[i], xd[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    int bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        #1;
        if (equal !== (a == b) || diff !== 4'(a ^ b)) begin
          bad++;
          if (bad <= 4)
            $display("FAIL exhaustive A=%0d B=%0d: got equal=%b diff=%b want equal=%b diff=%b",
                     a, b, equal, diff, (a == b), 4'(a ^ b));
        end
      end
    end
    nvec++;
    if (bad != 0) nerr++;
  endtask

  task automatic test_sequence();
    logic [3:0] va [4] = '{4'b0000, 4'b1010, 4'b1100, 4'b1111};
    logic [3:0] vb [4] = '{4'b0000, 4'b1010, 4'b0011, 4'b1110};
    logic       xe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      A = va[i];
      B = vb[i];
      sample = 1'b1;
      tick();
      nvec++;
      if (valid_q !== 1'b1 || equal_q !== xe[i]) begin
        nerr++;
        $display("FAIL seq_step%0d: got valid_q=%b equal_q=%b want 1 %b", i, valid_q, equal_q, xe[i]);
      end
    end
    sample = 1'b0;
    A = 4'b0101;
    B = 4'b0101;
    tick();
    nvec++;
    if (valid_q !== 1'b0 || equal_q !== 1'b0 || mismatch_seen !== 1'b1) begin
      nerr++;
      $display("FAIL seq_hold: got valid_q=%b equal_q=%b seen=%b want 0 0 1", valid_q, equal_q, mismatch_seen);
    end
`ifdef COMP_EQ_STATS_EN
    nvec++;
    if (match_cnt !== 2'd2 || mismatch_cnt !== 2'd2) begin
      nerr++;
      $display("FAIL seq_cnt: got match=%0d mismatch=%0d want 2 2", match_cnt, mismatch_cnt);
    end
`endif
  endtask

  task automatic test_saturation();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    nvec++;
    if (mismatch_seen !== 1'b0) begin
      nerr++;
      $display("FAIL clr_only: got seen=%b want 0", mismatch_seen);
    end
    A = 4'b0110;
    B = 4'b0110;
    sample = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (equal_q !== 1'b1 || mismatch_seen !== 1'b0) begin
        nerr++;
        $display("FAIL sat_step%0d: got equal_q=%b seen=%b want 1 0", i, equal_q, mismatch_seen);
      end
`ifdef COMP_EQ_STATS_EN
      nvec++;
      if (match_cnt !== 2'((i < 3) ? i + 1 : 3) || mismatch_cnt !== 2'd0) begin
        nerr++;
        $display("FAIL sat_cnt%0d: got match=%0d mismatch=%0d want %0d 0",
                 i, match_cnt, mismatch_cnt, (i < 3) ? i + 1 : 3);
      end
`endif
    end
    sample = 1'b0;
  endtask

  task automatic test_clr_sample();
    A = 4'b0011;
    B = 4'b0111;
    sample = 1'b1;
    tick();
    nvec++;
    if (mismatch_seen !== 1'b1) begin
      nerr++;
      $display("FAIL pre_clr_seen: got %b want 1", mismatch_seen);
    end
    A = 4'b0001;
    B = 4'b0000;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sample = 1'b0;
    nvec++;
    if (mismatch_seen !== 1'b0 || equal_q !== 1'b0 || valid_q !== 1'b1) begin
      nerr++;
      $display("FAIL clr_sample: got seen=%b equal_q=%b valid_q=%b want 0 0 1", mismatch_seen, equal_q, valid_q);
    end
`ifdef COMP_EQ_STATS_EN
    nvec++;
    if (match_cnt !== 2'd0 || mismatch_cnt !== 2'd0) begin
      nerr++;
      $display("FAIL clr_cnt: got match=%0d mismatch=%0d want 0 0", match_cnt, mismatch_cnt);
    end
`endif
    tick();
    nvec++;
    if (valid_q !== 1'b0) begin
      nerr++;
      $display("FAIL clr_after_valid: got %b want 0", valid_q);
    end
  endtask

  task automatic test_async_reset();
    A = 4'b1001;
    B = 4'b1001;
    sample = 1'b1;
    tick();
    A = 4'b1001;
    B = 4'b1000;
    tick();
    nvec++;
    if (valid_q !== 1'b1 || mismatch_seen !== 1'b1 || equal_q !== 1'b0) begin
      nerr++;
      $display("FAIL prereset: got valid_q=%b seen=%b equal_q=%b want 1 1 0", valid_q, mismatch_seen, equal_q);
    end
    A = 4'b1000;
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    A = 4'b0111;
    B = 4'b0111;
    #1;
    nvec++;
    if (equal !== 1'b1 || diff !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_comb: got equal=%b diff=%b want 1 0000", equal, diff);
    end
    sample = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_reset();
  endtask

  initial begin
    rst_n  = 1'b0;
    A      = 4'b0000;
    B      = 4'b0000;
    sample = 1'b0;
    clr    = 1'b0;
    #1;
    test_reset();
    test_comb_sweep();
    test_exhaustive();
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    test_sequence();
    test_saturation();
    test_clr_sample();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/comparator_4bit_eq.md
# comparator_4bit_eq

4-bit equality comparator with a combinational match output and a small clocked statistics section. The combinational path drives `equal` directly from operands `A` and `B` for use in datapath decode. The clocked section captures sampled results, counts matches and mismatches, and holds a sticky mismatch flag for status readout. It sits beside any 4-bit compare point needing both an immediate result and run-time match statistics.

## Interface
- `CNT_W`, default 8: width of the match and mismatch counters; legal range 2..16.
- `clk`  input  1  single clock; all registers update on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset; assertion immediately forces all registers to reset values; deassertion is synchronous to `clk` at the integration level.
- `A`  input  4  operand A.
- `B`  input  4  operand B.
- `sample`  input  1  when high at a rising edge, capture the current compare result into the registered outputs and statistics.
- `clr`  input  1  synchronous clear of statistics.
- `equal`  output  1  combinational; 1 iff `A == B` on all 4 bits.
- `diff`  output  4  combinational; `A ^ B`, where 1 marks a differing bit.
- `equal_q`  output  1  registered `equal` from the last sampled cycle.
- `valid_q`  output  1  1 for exactly the cycle after a rising edge with `sample=1`.
- `match_cnt`  output  CNT_W  saturating count of sampled matches; present only with `COMP_EQ_STATS_EN`.
- `mismatch_cnt`  output  CNT_W  saturating count of sampled mismatches; present only with `COMP_EQ_STATS_EN`.
- `mismatch_seen`  output  1  sticky; set by any sampled mismatch.

## Operation
- `equal` and `diff` are pure functions of `A` and `B`.
  - No dependence on `clk`, `rst_n`, `sample` or `clr`.
  - Valid during reset.
- Unsigned bitwise compare; no sign or ordering semantics.
- On a rising edge with `sample=1`:
  - `equal_q <= equal`
  - `valid_q <= 1`
  - if `equal`, `match_cnt` increments; otherwise `mismatch_cnt` increments and `mismatch_seen <= 1`.
- On a rising edge with `sample=0`: `valid_q <= 0`; `equal_q` and the statistics hold.
- Counter saturation: a counter at `2^CNT_W-1` holds and never wraps.
- `clr=1` at an edge:
  - `match_cnt`, `mismatch_cnt` and `mismatch_seen` go to 0.
  - Clear takes priority over a simultaneous `sample`: that sample does not count or set the sticky flag.
  - `equal_q` and `valid_q` still update normally from that sample.
- Reset values: `equal_q=0`, `valid_q=0`, `match_cnt=0`, `mismatch_cnt=0`, `mismatch_seen=0`.
- Reset mid-operation discards all accumulated state immediately and asynchronously.
- X/Z on any operand bit: `equal` may be X; the register behaviour under X is not specified.

## Timing
- `equal` and `diff`: zero-cycle combinational latency; settled within the input settle time, well under 10 ns in simulation.
- `equal_q`, `valid_q`, counters and sticky flag: 1-cycle latency from the sampling edge.
- No handshake or backpressure; `sample` may be asserted every cycle.
- Back-to-back samples each count independently.

## Configuration
- `COMP_EQ_STATS_EN` defined:
  - `match_cnt` and `mismatch_cnt` ports and counters are present.
  - Counter behaviour is as described under Operation.
- `COMP_EQ_STATS_EN` undefined:
  - The counter ports and counter logic are removed.
  - `equal`, `diff`, `equal_q`, `valid_q`, `mismatch_seen` and `clr` (which then clears only `mismatch_seen`) remain unchanged.

## Test plan
- Combinational sweep with no clock activity (`clk` idle, `rst_n=0`):
  - A=0000, B=0000 -> `equal=1`, `diff=0000`
  - A=1010, B=1010 -> `equal=1`, `diff=0000`
  - A=1100, B=0011 -> `equal=0`, `diff=1111`
  - A=1111, B=1110 -> `equal=0`, `diff=0001`
  - Each checked 10 ns after the input change.
- Exhaustive: all 256 A/B pairs -> `equal == (A==B)` and `diff == A^B`.
- Sampled sequence after reset: (0000,0000), (1010,1010), (1100,0011), (1111,1110) with `sample=1` -> `match_cnt=2`, `mismatch_cnt=2`, `mismatch_seen=1`; final `equal_q=0`; `valid_q` high for 4 cycles.
- Saturation (`CNT_W=2`): 5 sampled matches -> `match_cnt=3`, no wrap.
- `clr` and `sample` in the same cycle with A=0001, B=0000 -> counters=0, `mismatch_seen=0`, `equal_q=0`, `valid_q=1`.
- Assert `rst_n` low mid-sequence (off-edge) -> all registered outputs 0 immediately; `equal` still tracks the inputs.
